fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the in-order NPC pipeline, placed between the ID/EX register and the execute operand muxes. It resolves operand sources for up to NSRC consumers against the EX/LS, LS/WB and regfile-write stages. It also runs a small FSM that stalls the front end and inserts bubbles until a dependent load's multi-cycle LSU response arrives. The optional performance counters expose stall statistics.

---
 rtl/fwd_hazard_unit.sv | 150 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the ID/EX stage of the NPC pipeline.
// Optional perf counters are enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_unit #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int NSRC = 2,
    parameter int CNTW = 32
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic [NSRC*RAW-1:0]  id_rs_i,
    input  logic [NSRC-1:0]      id_rs_en_i,
    input  logic [NSRC*XLEN-1:0] rf_data_i,
    input  logic [RAW-1:0]       ex_rd_i,
    input  logic                 ex_wen_i,
    input  logic                 ex_is_load_i,
    input  logic [XLEN-1:0]      ex_data_i,
    input  logic [RAW-1:0]       ls_rd_i,
    input  logic                 ls_wen_i,
    input  logic                 ls_is_load_i,
    input  logic [XLEN-1:0]      ls_data_i,
    input  logic                 ls_rvalid_i,
    input  logic [RAW-1:0]       wb_rd_i,
    input  logic                 wb_wen_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [NSRC*XLEN-1:0] opnd_o,
    output logic [NSRC*2-1:0]    fwd_sel_o,
    output logic                 stall_o,
    output logic                 bubble_o,
    output logic [CNTW-1:0]      stall_cycles_o,
    output logic [CNTW-1:0]      ld_stalls_o
);

    typedef enum logic {
        RUN    = 1'b0,
        LDWAIT = 1'b1
    } state_t;

    state_t          state;
    logic [RAW-1:0]  pend_rd;
    logic [RAW-1:0]  rs;
    logic            ex_hit;
    logic            ls_hit;
    logic            wb_hit;
    logic            ex_load_hit;
    logic            ls_load_miss;
    logic            stall_hit;
    logic            stall;

    // A loaded value that is not yet available is skipped so a lower-priority
    // stage may still be selected; the consumer ignores it while stalled anyway.
    always_comb begin
        opnd_o       = rf_data_i;
        fwd_sel_o    = '0;
        ex_load_hit  = 1'b0;
        ls_load_miss = 1'b0;
        rs           = '0;
        ex_hit       = 1'b0;
        ls_hit       = 1'b0;
        wb_hit       = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            rs     = id_rs_i[k*RAW +: RAW];
            ex_hit = id_rs_en_i[k] && (rs != '0) && ex_wen_i && (ex_rd_i == rs);
            ls_hit = id_rs_en_i[k] && (rs != '0) && ls_wen_i && (ls_rd_i == rs);
            wb_hit = id_rs_en_i[k] && (rs != '0) && wb_wen_i && (wb_rd_i == rs);
            if (ex_hit && !ex_is_load_i) begin
                fwd_sel_o[k*2 +: 2]  = 2'd1;
                opnd_o[k*XLEN +: XLEN] = ex_data_i;
            end else if (ls_hit && (!ls_is_load_i || ls_rvalid_i)) begin
                fwd_sel_o[k*2 +: 2]  = 2'd2;
                opnd_o[k*XLEN +: XLEN] = ls_data_i;
            end else if (wb_hit) begin
                fwd_sel_o[k*2 +: 2]  = 2'd3;
                opnd_o[k*XLEN +: XLEN] = wb_data_i;
            end
            ex_load_hit  = ex_load_hit  | (ex_hit && ex_is_load_i);
            ls_load_miss = ls_load_miss | (ls_hit && ls_is_load_i && !ls_rvalid_i);
        end
    end

    assign stall_hit = ex_load_hit | ls_load_miss;

    // Reset is folded in so the stall drops the instant reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (rst_n && !flush_i) begin
            if (state == RUN) stall = stall_hit;
            else              stall = !ls_rvalid_i;
        end
    end

    assign stall_o  = stall;
    assign bubble_o = stall;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pend_rd <= '0;
        end else if (flush_i) begin
            state   <= RUN;
            pend_rd <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (stall_hit) begin
                        state   <= LDWAIT;
                        pend_rd <= ex_load_hit ? ex_rd_i : ls_rd_i;
                    end
                end
                LDWAIT: begin
                    if (ls_rvalid_i && (ls_rd_i == pend_rd)) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response for a different register while waiting means the LSU and pipeline disagree.
    always_ff @(posedge clock) begin
        if (rst_n && !flush_i && (state == LDWAIT) && ls_rvalid_i)
            assert (ls_rd_i == pend_rd);
    end
`endif

`ifdef FWD_HAZARD_PERF_EN
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] ld_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            ld_cnt    <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if ((state == RUN) && !flush_i && stall_hit && (ld_cnt != '1))
                ld_cnt <= ld_cnt + 1'b1;
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign ld_stalls_o    = ld_cnt;
`else
    assign stall_cycles_o = '0;
    assign ld_stalls_o    = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding vector table plus load-use,
// flush and reset sequences. Counter expectations follow FWD_HAZARD_PERF_EN.
module tb_fwd_hazard_unit;

    logic        clock;
    logic        rst_n;
    logic        flush_i;
    logic [9:0]  id_rs_i;
    logic [1:0]  id_rs_en_i;
    logic [63:0] rf_data_i;
    logic [4:0]  ex_rd_i;
    logic        ex_wen_i;
    logic        ex_is_load_i;
    logic [31:0] ex_data_i;
    logic [4:0]  ls_rd_i;
    logic        ls_wen_i;
    logic        ls_is_load_i;
    logic [31:0] ls_data_i;
    logic        ls_rvalid_i;
    logic [4:0]  wb_rd_i;
    logic        wb_wen_i;
    logic [31:0] wb_data_i;
    logic [63:0] opnd_o;
    logic [3:0]  fwd_sel_o;
    logic        stall_o;
    logic        bubble_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] ld_stalls_o;

    int testsRun;
    int testsFailed;
    bit perfOn;

    fwd_hazard_unit dut (
        .clock(clock), .rst_n(rst_n), .flush_i(flush_i),
        .id_rs_i(id_rs_i), .id_rs_en_i(id_rs_en_i), .rf_data_i(rf_data_i),
        .ex_rd_i(ex_rd_i), .ex_wen_i(ex_wen_i), .ex_is_load_i(ex_is_load_i), .ex_data_i(ex_data_i),
        .ls_rd_i(ls_rd_i), .ls_wen_i(ls_wen_i), .ls_is_load_i(ls_is_load_i), .ls_data_i(ls_data_i),
        .ls_rvalid_i(ls_rvalid_i),
        .wb_rd_i(wb_rd_i), .wb_wen_i(wb_wen_i), .wb_data_i(wb_data_i),
        .opnd_o(opnd_o), .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .bubble_o(bubble_o),
        .stall_cycles_o(stall_cycles_o), .ld_stalls_o(ld_stalls_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rs0, rs1;
        logic [1:0]  en;
        logic [4:0]  exRd;
        logic        exWen, exLd;
        logic [31:0] exData;
        logic [4:0]  lsRd;
        logic        lsWen, lsLd, rvalid;
        logic [31:0] lsData;
        logic [4:0]  wbRd;
        logic        wbWen;
        logic [31:0] wbData;
        logic [1:0]  sel0, sel1;
        logic [31:0] op0, op1;
        logic        stall;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_rs_i      = {v.rs1, v.rs0};
        id_rs_en_i   = v.en;
        ex_rd_i      = v.exRd;
        ex_wen_i     = v.exWen;
        ex_is_load_i = v.exLd;
        ex_data_i    = v.exData;
        ls_rd_i      = v.lsRd;
        ls_wen_i     = v.lsWen;
        ls_is_load_i = v.lsLd;
        ls_rvalid_i  = v.rvalid;
        ls_data_i    = v.lsData;
        wb_rd_i      = v.wbRd;
        wb_wen_i     = v.wbWen;
        wb_data_i    = v.wbData;
    endtask

    task automatic idle();
        flush_i      = 1'b0;
        id_rs_i      = '0;
        id_rs_en_i   = '0;
        ex_rd_i      = '0; ex_wen_i = 1'b0; ex_is_load_i = 1'b0; ex_data_i = '0;
        ls_rd_i      = '0; ls_wen_i = 1'b0; ls_is_load_i = 1'b0; ls_data_i = '0;
        ls_rvalid_i  = 1'b0;
        wb_rd_i      = '0; wb_wen_i = 1'b0; wb_data_i = '0;
    endtask

    // Load x7 sits in EX while the consumer reads it as operand 1.
    task automatic loadInEx();
        idle();
        id_rs_i      = {5'd7, 5'd0};
        id_rs_en_i   = 2'b10;
        ex_rd_i      = 5'd7;
        ex_wen_i     = 1'b1;
        ex_is_load_i = 1'b1;
    endtask

    // The load has moved on to LS and EX holds the bubble.
    task automatic loadInLs(input logic rvalid, input logic [31:0] data);
        idle();
        id_rs_i      = {5'd7, 5'd0};
        id_rs_en_i   = 2'b10;
        ls_rd_i      = 5'd7;
        ls_wen_i     = 1'b1;
        ls_is_load_i = 1'b1;
        ls_rvalid_i  = rvalid;
        ls_data_i    = data;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        perfOn      = 1'b0;
`ifdef FWD_HAZARD_PERF_EN
        perfOn      = 1'b1;
`endif
        //           rs0 rs1 en     exRd exW exL exData       lsRd lsW lsL rv lsData        wbRd wbW wbData     s0 s1 op0           op1           st
        vecs[0] = '{5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 32'h0,      5'd0, 0, 0, 0, 32'h0,        5'd0, 0, 32'h0,    2'd0, 2'd0, 32'hA0, 32'hB0,       0};
        vecs[1] = '{5'd5, 5'd0, 2'b01, 5'd5, 1, 0, 32'h11,     5'd0, 0, 0, 0, 32'h0,        5'd0, 0, 32'h0,    2'd1, 2'd0, 32'h11, 32'hB0,       0};
        vecs[2] = '{5'd5, 5'd0, 2'b01, 5'd5, 1, 0, 32'h11,     5'd5, 1, 0, 0, 32'h22,       5'd5, 1, 32'h33,   2'd1, 2'd0, 32'h11, 32'hB0,       0};
        vecs[3] = '{5'd5, 5'd0, 2'b01, 5'd5, 0, 0, 32'h11,     5'd5, 1, 0, 0, 32'h22,       5'd5, 1, 32'h33,   2'd2, 2'd0, 32'h22, 32'hB0,       0};
        vecs[4] = '{5'd5, 5'd0, 2'b01, 5'd5, 0, 0, 32'h11,     5'd5, 0, 0, 0, 32'h22,       5'd5, 1, 32'h33,   2'd3, 2'd0, 32'h33, 32'hB0,       0};
        vecs[5] = '{5'd0, 5'd0, 2'b01, 5'd0, 1, 0, 32'h5,      5'd0, 1, 0, 0, 32'h5,        5'd0, 1, 32'h5,    2'd0, 2'd0, 32'hA0, 32'hB0,       0};
        vecs[6] = '{5'd5, 5'd0, 2'b00, 5'd5, 1, 0, 32'h11,     5'd0, 0, 0, 0, 32'h0,        5'd0, 0, 32'h0,    2'd0, 2'd0, 32'hA0, 32'hB0,       0};
        vecs[7] = '{5'd0, 5'd7, 2'b10, 5'd0, 0, 0, 32'h0,      5'd7, 1, 1, 1, 32'hDEADBEEF, 5'd0, 0, 32'h0,    2'd0, 2'd2, 32'hA0, 32'hDEADBEEF, 0};
        vecs[8] = '{5'd5, 5'd6, 2'b11, 5'd5, 1, 0, 32'h11,     5'd0, 0, 0, 0, 32'h0,        5'd6, 1, 32'h66,   2'd1, 2'd3, 32'h11, 32'h66,       0};
        vecs[9] = '{5'd9, 5'd9, 2'b11, 5'd0, 0, 0, 32'h0,      5'd9, 1, 0, 0, 32'h99,       5'd9, 1, 32'h77,   2'd2, 2'd2, 32'h99, 32'h99,       0};

        rf_data_i = {32'hB0, 32'hA0};
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #2;
        checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("reset_bubble", {31'd0, bubble_o}, 32'd0);
        checkOutput("reset_sel", {28'd0, fwd_sel_o}, 32'd0);
        checkOutput("reset_opnd0", opnd_o[31:0], 32'hA0);
        checkOutput("reset_stall_cycles", stall_cycles_o, 32'd0);
        checkOutput("reset_ld_stalls", ld_stalls_o, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d_sel0", i), {30'd0, fwd_sel_o[1:0]}, {30'd0, vecs[i].sel0});
            checkOutput($sformatf("vec%0d_sel1", i), {30'd0, fwd_sel_o[3:2]}, {30'd0, vecs[i].sel1});
            checkOutput($sformatf("vec%0d_opnd0", i), opnd_o[31:0], vecs[i].op0);
            checkOutput($sformatf("vec%0d_opnd1", i), opnd_o[63:32], vecs[i].op1);
            checkOutput($sformatf("vec%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].stall});
        end

        // Three-cycle LSU: stall in the EX cycle plus two LS cycles without a response.
        @(negedge clock); loadInEx(); #2;
        checkOutput("lu3_c1_stall", {31'd0, stall_o}, 32'd1);
        checkOutput("lu3_c1_bubble", {31'd0, bubble_o}, 32'd1);
        @(negedge clock); loadInLs(1'b0, 32'h0); #2;
        checkOutput("lu3_c2_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clock); loadInLs(1'b0, 32'h0); #2;
        checkOutput("lu3_c3_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clock); loadInLs(1'b1, 32'hDEADBEEF); #2;
        checkOutput("lu3_c4_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("lu3_c4_sel1", {30'd0, fwd_sel_o[3:2]}, 32'd2);
        checkOutput("lu3_c4_opnd1", opnd_o[63:32], 32'hDEADBEEF);
        @(negedge clock); idle(); #2;
        checkOutput("lu3_back_run", {31'd0, stall_o}, 32'd0);
        checkOutput("lu3_stall_cycles", stall_cycles_o, perfOn ? 32'd3 : 32'd0);
        checkOutput("lu3_ld_stalls", ld_stalls_o, perfOn ? 32'd1 : 32'd0);

        // One-cycle LSU: response arrives in the first LS cycle.
        @(negedge clock); loadInEx(); #2;
        checkOutput("lu1_c1_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clock); loadInLs(1'b1, 32'h12345678); #2;
        checkOutput("lu1_c2_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("lu1_c2_opnd1", opnd_o[63:32], 32'h12345678);
        @(negedge clock); idle(); #2;
        checkOutput("lu1_back_run", {31'd0, stall_o}, 32'd0);
        checkOutput("lu1_stall_cycles", stall_cycles_o, perfOn ? 32'd4 : 32'd0);
        checkOutput("lu1_ld_stalls", ld_stalls_o, perfOn ? 32'd2 : 32'd0);

        // Flush while waiting: stall drops that cycle and the FSM returns to RUN.
        @(negedge clock); loadInEx(); #2;
        checkOutput("fl_c1_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clock); loadInLs(1'b0, 32'h0); flush_i = 1'b1; #2;
        checkOutput("fl_c2_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clock); idle(); #2;
        checkOutput("fl_run_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("fl_stall_cycles", stall_cycles_o, perfOn ? 32'd5 : 32'd0);
        checkOutput("fl_ld_stalls", ld_stalls_o, perfOn ? 32'd3 : 32'd0);

        // Asynchronous reset in the middle of a wait.
        @(negedge clock); loadInEx(); #2;
        checkOutput("rs_c1_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clock); idle(); #2;
        checkOutput("rs_wait_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clock); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rs_async_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rs_async_stall_cycles", stall_cycles_o, 32'd0);
        checkOutput("rs_async_ld_stalls", ld_stalls_o, 32'd0);
        @(negedge clock); rst_n = 1'b1; #2;
        checkOutput("rs_run_stall", {31'd0, stall_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
